fetch_unit: RTL and testbench

- Instruction fetch front end feeding the decode / control unit and immediate generator.
- Owns the PC register and issues word requests to instruction memory over a request/response handshake.
- Buffers each returned instruction in an IF/ID output register, with stall, redirect (branch/jump target) and discard of stale responses.
- Sustained throughput is one instruction per two cycles; a one-entry skid buffer absorbs responses that arrive while decode is stalled.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_skid_buf.sv | 58 +++++
 rtl/fetch_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch front end.
//   - fetch_state_t : request / wait-for-response / hold-in-skid states
//   - fetch_entry_t : {instr, pc} pair used by both the skid buffer and the
//                     IF/ID output register
//   - FETCH_NOP     : canonical NOP (addi x0,x0,0) shown when the output is empty
// The entry fields are sized from FETCH_DATA_W / FETCH_ADDR_W; a fetch_unit
// built with different DATA_WIDTH / ADDR_WIDTH needs these changed to match.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned FETCH_ADDR_W = 32;

  localparam logic [FETCH_DATA_W-1:0] FETCH_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // presenting a request to instruction memory
    WAIT = 2'd1,  // one request outstanding, waiting for its response
    HOLD = 2'd2   // response parked in the skid buffer, decode stalled
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding register for an instruction response that arrived while
// the IF/ID output register was occupied and stalled.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset (clears the valid flag only)
//   load_i   in   capture entry_i
//   drain_i  in   entry consumed by the output register this cycle
//   flush_i  in   entry discarded (redirect)
//   entry_i  in   {instr, pc} to capture
//   entry_o  out  held {instr, pc}
//   valid_o  out  buffer holds a live entry
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         valid_o
);

  logic         vld_q, vld_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    vld_d   = vld_q;
    entry_d = entry_q;
    if (load_i) begin
      vld_d   = 1'b1;
      entry_d = entry_i;
    end else if (drain_i || flush_i) begin
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  assign entry_o = entry_q;
  assign valid_o = vld_q;

endmodule : fetch_skid_buf

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: owns the PC, issues one word request at a time
// to instruction memory, and presents each returned instruction in an IF/ID
// output register. Handles decode stall (via a one-entry skid buffer),
// branch/jump redirect, and discard of responses made stale by a redirect.
// Ports:
//   clk_i          in   clock, rising edge
//   rst_ni         in   asynchronous active-low reset
//   imem_req_o     out  request valid (only in REQ)
//   imem_addr_o    out  word-aligned fetch address (= pc_q)
//   imem_ready_i   in   memory accepts the request this cycle
//   imem_rvalid_i  in   response valid, one per accepted request
//   imem_rdata_i   in   response instruction word
//   stall_i        in   decode cannot consume the output this cycle
//   redirect_i     in   taken branch/jump, refetch from redirect_pc_i
//   redirect_pc_i  in   redirect target (low two bits ignored for the fetch)
//   valid_o        out  instr_o / pc_o hold a live instruction
//   instr_o        out  instruction to decode (NOP when empty)
//   pc_o           out  address of instr_o
//   pc_plus4_o     out  pc_o + 4, wrapping
//   misaligned_o   out  one-cycle pulse after a redirect with nonzero low bits
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH = FETCH_DATA_W,
  parameter int unsigned             ADDR_WIDTH = FETCH_ADDR_W,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0]   NOP_INSTR  = FETCH_NOP
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  misaligned_o
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  discard_q, discard_d;
  logic                  out_vld_q, out_vld_d;
  fetch_entry_t          out_q, out_d;
  logic                  misaligned_q, misaligned_d;

  logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
  logic                  out_free;
  logic                  resp_load;
  logic                  skid_load;
  logic                  skid_drain;
  logic                  skid_flush;
  logic                  skid_vld;
  fetch_entry_t          skid_entry;
  fetch_entry_t          resp_entry;

  assign redirect_pc_aligned = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  // The output register can take a new entry if it is empty or being consumed.
  assign out_free            = !out_vld_q || !stall_i;
  assign resp_entry          = '{instr: imem_rdata_i, pc: req_pc_q};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        // A redirect does not retract a request the memory is accepting.
        if (imem_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_i) begin
          // Stay until the stale response shows up, unless it is here now.
          if (imem_rvalid_i) state_d = REQ;
        end else if (imem_rvalid_i) begin
          state_d = (discard_q || out_free) ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (redirect_i || (skid_vld && !stall_i)) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req_o = (state_q == REQ);
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    resp_load  = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_flush = 1'b0;
    case (state_q)
      REQ: begin
        if (imem_ready_i) begin
          req_pc_d  = pc_q;
          pc_d      = pc_q + PC_STEP;
          // Accepted together with a redirect: its response is already stale.
          discard_d = redirect_i;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          // A response arriving in the redirect cycle is dropped right here;
          // otherwise remember to drop it when it comes.
          discard_d = !imem_rvalid_i;
        end else if (imem_rvalid_i) begin
          discard_d = 1'b0;
          if (!discard_q) begin
            if (out_free) resp_load = 1'b1;
            else          skid_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_i)                skid_flush = 1'b1;
        else if (skid_vld && !stall_i) skid_drain = 1'b1;
      end
      default: ;
    endcase
    if (redirect_i) pc_d = redirect_pc_aligned;
  end

  // ---------------------------------------------------------------------------
  // IF/ID output register next value: redirect > load > consume
  // ---------------------------------------------------------------------------
  always_comb begin
    out_vld_d    = out_vld_q;
    out_d        = out_q;
    misaligned_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    if (redirect_i) begin
      out_vld_d   = 1'b0;
      out_d.instr = NOP_INSTR;
    end else if (resp_load) begin
      out_vld_d   = 1'b1;
      out_d       = resp_entry;
    end else if (skid_drain) begin
      out_vld_d   = 1'b1;
      out_d       = skid_entry;
    end else if (out_vld_q && !stall_i) begin
      out_vld_d   = 1'b0;
      out_d.instr = NOP_INSTR;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_q        <= '{instr: NOP_INSTR, pc: RESET_PC};
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      out_vld_q    <= out_vld_d;
      out_q        <= out_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Only meaningful while in WAIT, which reset always leaves.
  always_ff @(posedge clk_i) begin
    req_pc_q <= req_pc_d;
  end

  fetch_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (skid_flush),
    .entry_i (resp_entry),
    .entry_o (skid_entry),
    .valid_o (skid_vld)
  );

  assign imem_addr_o  = pc_q;
  assign valid_o      = out_vld_q;
  assign instr_o      = out_q.instr;
  assign pc_o         = out_q.pc;
  assign pc_plus4_o   = out_q.pc + PC_STEP;
  assign misaligned_o = misaligned_q;

  // The skid buffer is occupied exactly while the FSM sits in HOLD.
  hold_has_skid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == HOLD) == skid_vld);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;

  typedef struct {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        misaligned_o;

  int errors = 0;
  int checks = 0;
  vec_t v[$];

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .misaligned_o  (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ready, input logic rvalid, input logic [31:0] rdata,
                              input logic stall, input logic redir, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_mis);
    vec_t r;
    r.ready = ready;  r.rvalid = rvalid;   r.rdata = rdata;     r.stall = stall;
    r.redir = redir;  r.rpc = rpc;         r.e_req = e_req;     r.e_addr = e_addr;
    r.e_valid = e_valid; r.e_instr = e_instr; r.e_pc = e_pc;    r.e_mis = e_mis;
    return r;
  endfunction

  task automatic drive_idle();
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
  endtask

  initial begin
    // Each row: inputs presented for the coming rising edge, and the outputs
    // expected in that same cycle (i.e. the result of all earlier edges).
    //             rdy rv  rdata          stl red rpc           | req addr          vld instr          pc             mis
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0000, L, NOP,           32'h0,         L)); // c0
    v.push_back(mk(L, H, K|32'h000,      L, L, 32'h0,          L, 32'h0000_0004, L, NOP,           32'h0,         L)); // c1
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0004, H, K|32'h000,     32'h0000_0000, L)); // c2
    v.push_back(mk(L, H, K|32'h004,      L, L, 32'h0,          L, 32'h0000_0008, L, NOP,           32'h0,         L)); // c3
    v.push_back(mk(H, L, 32'h0,          H, L, 32'h0,          H, 32'h0000_0008, H, K|32'h004,     32'h0000_0004, L)); // c4
    v.push_back(mk(L, H, K|32'h008,      H, L, 32'h0,          L, 32'h0000_000C, H, K|32'h004,     32'h0000_0004, L)); // c5
    v.push_back(mk(L, L, 32'h0,          H, L, 32'h0,          L, 32'h0000_000C, H, K|32'h004,     32'h0000_0004, L)); // c6 HOLD
    v.push_back(mk(L, L, 32'h0,          L, L, 32'h0,          L, 32'h0000_000C, H, K|32'h004,     32'h0000_0004, L)); // c7 release
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_000C, H, K|32'h008,     32'h0000_0008, L)); // c8
    v.push_back(mk(L, H, K|32'h00C,      L, L, 32'h0,          L, 32'h0000_0010, L, NOP,           32'h0,         L)); // c9
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0010, H, K|32'h00C,     32'h0000_000C, L)); // c10
    v.push_back(mk(L, L, 32'h0,          L, H, 32'h0000_0100,  L, 32'h0000_0014, L, NOP,           32'h0,         L)); // c11 redirect in WAIT
    v.push_back(mk(L, H, K|32'h010,      L, L, 32'h0,          L, 32'h0000_0100, L, NOP,           32'h0,         L)); // c12 stale resp
    v.push_back(mk(L, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0100, L, NOP,           32'h0,         L)); // c13 not ready
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0100, L, NOP,           32'h0,         L)); // c14
    v.push_back(mk(L, H, K|32'h100,      L, L, 32'h0,          L, 32'h0000_0104, L, NOP,           32'h0,         L)); // c15
    v.push_back(mk(H, L, 32'h0,          L, H, 32'h0000_0200,  H, 32'h0000_0104, H, K|32'h100,     32'h0000_0100, L)); // c16 redirect+accept
    v.push_back(mk(L, H, K|32'h104,      L, L, 32'h0,          L, 32'h0000_0200, L, NOP,           32'h0,         L)); // c17 dropped
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0200, L, NOP,           32'h0,         L)); // c18
    v.push_back(mk(L, H, K|32'h200,      L, L, 32'h0,          L, 32'h0000_0204, L, NOP,           32'h0,         L)); // c19
    v.push_back(mk(L, L, 32'h0,          L, H, 32'h0000_0106,  H, 32'h0000_0204, H, K|32'h200,     32'h0000_0200, L)); // c20 misaligned
    v.push_back(mk(L, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0104, L, NOP,           32'h0,         H)); // c21 pulse
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0104, L, NOP,           32'h0,         L)); // c22
    v.push_back(mk(L, H, K|32'h104,      L, L, 32'h0,          L, 32'h0000_0108, L, NOP,           32'h0,         L)); // c23
    v.push_back(mk(L, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0108, H, K|32'h104,     32'h0000_0104, L)); // c24
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0108, L, NOP,           32'h0,         L)); // c25
    v.push_back(mk(L, H, K|32'h108,      L, H, 32'h0000_0300,  L, 32'h0000_010C, L, NOP,           32'h0,         L)); // c26 redirect+rvalid
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'h0000_0300, L, NOP,           32'h0,         L)); // c27
    v.push_back(mk(L, H, K|32'h300,      L, L, 32'h0,          L, 32'h0000_0304, L, NOP,           32'h0,         L)); // c28
    v.push_back(mk(H, L, 32'h0,          H, L, 32'h0,          H, 32'h0000_0304, H, K|32'h300,     32'h0000_0300, L)); // c29
    v.push_back(mk(L, H, K|32'h304,      H, L, 32'h0,          L, 32'h0000_0308, H, K|32'h300,     32'h0000_0300, L)); // c30 to HOLD
    v.push_back(mk(L, L, 32'h0,          H, H, 32'h0000_0400,  L, 32'h0000_0308, H, K|32'h300,     32'h0000_0300, L)); // c31 redirect in HOLD
    v.push_back(mk(L, L, 32'h0,          L, H, 32'hFFFF_FFFC,  H, 32'h0000_0400, L, NOP,           32'h0,         L)); // c32
    v.push_back(mk(H, L, 32'h0,          L, L, 32'h0,          H, 32'hFFFF_FFFC, L, NOP,           32'h0,         L)); // c33
    v.push_back(mk(L, H, 32'h5A5A_FFFC,  L, L, 32'h0,          L, 32'h0000_0000, L, NOP,           32'h0,         L)); // c34
    v.push_back(mk(H, L, 32'h0,          H, L, 32'h0,          H, 32'h0000_0000, H, 32'h5A5A_FFFC, 32'hFFFF_FFFC, L)); // c35

    drive_idle();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk1("rst req",   imem_req_o,   1'b1);
    chk ("rst addr",  imem_addr_o,  32'h0);
    chk1("rst valid", valid_o,      1'b0);
    chk ("rst instr", instr_o,      NOP);
    chk ("rst pc",    pc_o,         32'h0);
    chk ("rst pc4",   pc_plus4_o,   32'h4);
    chk1("rst mis",   misaligned_o, 1'b0);
    rst_ni = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      chk1($sformatf("c%0d req", i),   imem_req_o,   v[i].e_req);
      chk ($sformatf("c%0d addr", i),  imem_addr_o,  v[i].e_addr);
      chk1($sformatf("c%0d valid", i), valid_o,      v[i].e_valid);
      chk ($sformatf("c%0d instr", i), instr_o,      v[i].e_instr);
      chk1($sformatf("c%0d mis", i),   misaligned_o, v[i].e_mis);
      if (v[i].e_valid) begin
        chk($sformatf("c%0d pc", i),  pc_o,       v[i].e_pc);
        chk($sformatf("c%0d pc4", i), pc_plus4_o, v[i].e_pc + 32'd4);
      end
      imem_ready_i  = v[i].ready;
      imem_rvalid_i = v[i].rvalid;
      imem_rdata_i  = v[i].rdata;
      stall_i       = v[i].stall;
      redirect_i    = v[i].redir;
      redirect_pc_i = v[i].rpc;
      @(negedge clk_i);
    end

    // Wrap: output holds pc FFFF_FFFC (stalled) while fetch of 0 is in WAIT.
    drive_idle();
    stall_i = 1'b1;
    chk ("wrap pc4",   pc_plus4_o,  32'h0000_0000);
    chk ("wrap addr",  imem_addr_o, 32'h0000_0004);
    chk1("wrap req",   imem_req_o,  1'b0);
    chk1("wrap valid", valid_o,     1'b1);

    // Asynchronous reset in the middle of WAIT, checked before any clock edge.
    #2 rst_ni = 1'b0;
    #1;
    chk1("arst valid", valid_o,      1'b0);
    chk ("arst instr", instr_o,      NOP);
    chk ("arst pc",    pc_o,         32'h0);
    chk ("arst pc4",   pc_plus4_o,   32'h4);
    chk1("arst req",   imem_req_o,   1'b1);
    chk ("arst addr",  imem_addr_o,  32'h0);

    // Late response to the pre-reset request must be ignored.
    @(negedge clk_i);
    rst_ni        = 1'b1;
    stall_i       = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk1("late valid", valid_o,     1'b0);
    chk ("late instr", instr_o,     NOP);
    chk1("late req",   imem_req_o,  1'b1);
    chk ("late addr",  imem_addr_o, 32'h0);
    imem_rvalid_i = 1'b0;
    imem_ready_i  = 1'b1;
    @(negedge clk_i);
    chk1("post req",   imem_req_o,  1'b0);
    chk ("post addr",  imem_addr_o, 32'h4);
    imem_ready_i  = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = K;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0;
    chk1("post valid", valid_o,     1'b1);
    chk ("post pc",    pc_o,        32'h0);
    chk ("post instr", instr_o,     K);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_unit
